// File: rtl/uart_fifo_tx.sv
// FIFO-buffered 8-bit UART transmitter, LSB first, 8N1 by default.
// Define UART_TX_PARITY_EN to add an even-parity bit between data and stop.
module uart_fifo_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int DEPTH        = 8
) (
  input  logic       i_Clock,
  input  logic       i_Reset_n,
  input  logic       i_Tx_DV,
  input  logic [7:0] i_Tx_Byte,
  output logic       o_Full,
  output logic       o_Empty,
  output logic       o_Overflow,
  output logic       o_Tx_Serial,
  output logic       o_Tx_Active,
  output logic       o_Tx_Done
);

  localparam int            AW       = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [7:0]    CNT_MAX  = 8'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, CLEANUP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, CLEANUP} state_t;
`endif

  state_t        state;
  logic [7:0]    fifo_mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_nxt;
  logic          wr_en;
  logic          rd_en;
  logic [7:0]    tx_data;
  logic [7:0]    clk_cnt;
  logic [2:0]    bit_idx;
  logic [2:0]    bit_nxt;
  logic          bit_end;

  // A pop frees a slot only from the next cycle on, since o_Full is registered.
  assign wr_en   = i_Tx_DV && !o_Full;
  assign rd_en   = (state == IDLE) && !o_Empty;
  assign bit_end = (clk_cnt == CNT_MAX);
  assign bit_nxt = bit_idx + 3'd1;

  always_comb begin
    count_nxt = count;
    if (wr_en && !rd_en) begin
      count_nxt = count + CNT_ONE;
    end else if (!wr_en && rd_en) begin
      count_nxt = count - CNT_ONE;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (wr_en) begin
      fifo_mem[wr_ptr] <= i_Tx_Byte;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (rd_en) begin
      tx_data <= fifo_mem[rd_ptr];
    end
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      o_Full     <= 1'b0;
      o_Empty    <= 1'b1;
      o_Overflow <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      count      <= count_nxt;
      o_Full     <= (count_nxt == CNT_FULL);
      o_Empty    <= (count_nxt == '0);
      o_Overflow <= i_Tx_DV && o_Full;
    end
  end

  // Serial outputs are registered and set on the edge that enters each bit.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state       <= IDLE;
      clk_cnt     <= '0;
      bit_idx     <= '0;
      o_Tx_Serial <= 1'b1;
      o_Tx_Active <= 1'b0;
      o_Tx_Done   <= 1'b0;
    end else begin
      o_Tx_Done <= 1'b0;
      case (state)
        IDLE: begin
          o_Tx_Serial <= 1'b1;
          clk_cnt     <= '0;
          bit_idx     <= '0;
          if (!o_Empty) begin
            state       <= START;
            o_Tx_Serial <= 1'b0;
            o_Tx_Active <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            clk_cnt     <= '0;
            state       <= DATA;
            o_Tx_Serial <= tx_data[0];
          end else begin
            clk_cnt <= clk_cnt + 8'd1;
          end
        end
        DATA: begin
          if (bit_end) begin
            clk_cnt <= '0;
            if (bit_idx == 3'd7) begin
              bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
              state       <= PARITY;
              o_Tx_Serial <= ^tx_data;
`else
              state       <= STOP;
              o_Tx_Serial <= 1'b1;
`endif
            end else begin
              bit_idx     <= bit_nxt;
              o_Tx_Serial <= tx_data[bit_nxt];
            end
          end else begin
            clk_cnt <= clk_cnt + 8'd1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            clk_cnt     <= '0;
            state       <= STOP;
            o_Tx_Serial <= 1'b1;
          end else begin
            clk_cnt <= clk_cnt + 8'd1;
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            clk_cnt     <= '0;
            state       <= CLEANUP;
            o_Tx_Active <= 1'b0;
            o_Tx_Done   <= 1'b1;
          end else begin
            clk_cnt <= clk_cnt + 8'd1;
          end
        end
        CLEANUP: begin
          o_Tx_Serial <= 1'b1;
          state       <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_fifo_tx.sv
// Bench for uart_fifo_tx: a serial-line monitor decodes frames and checks them
// against a queue of expected bytes pushed by the directed stimulus.
module tb_uart_fifo_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 8;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int SPACING = FRAME_BITS * CPB + 2;

  logic       i_Clock   = 1'b0;
  logic       i_Reset_n = 1'b0;
  logic       i_Tx_DV   = 1'b0;
  logic [7:0] i_Tx_Byte = 8'h00;
  logic       o_Full;
  logic       o_Empty;
  logic       o_Overflow;
  logic       o_Tx_Serial;
  logic       o_Tx_Active;
  logic       o_Tx_Done;

  int         n_checks   = 0;
  int         n_fails    = 0;
  int         cyc        = 0;
  int         done_cnt   = 0;
  int         mon_frames = 0;
  int         mon_starts = 0;
  int         wr_cyc     = 0;
  logic [7:0] exp_q[$];
  int         start_q[$];

  uart_fifo_tx #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
    .i_Clock    (i_Clock),
    .i_Reset_n  (i_Reset_n),
    .i_Tx_DV    (i_Tx_DV),
    .i_Tx_Byte  (i_Tx_Byte),
    .o_Full     (o_Full),
    .o_Empty    (o_Empty),
    .o_Overflow (o_Overflow),
    .o_Tx_Serial(o_Tx_Serial),
    .o_Tx_Active(o_Tx_Active),
    .o_Tx_Done  (o_Tx_Done)
  );

  always #5 i_Clock = ~i_Clock;

  always @(posedge i_Clock) cyc <= cyc + 1;

  always @(negedge i_Clock) begin
    if (o_Tx_Done === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic write_byte(input logic [7:0] b, input bit accept);
    @(negedge i_Clock);
    i_Tx_DV   = 1'b1;
    i_Tx_Byte = b;
    wr_cyc    = cyc + 1;
    if (accept) exp_q.push_back(b);
  endtask

  task automatic dv_off();
    @(negedge i_Clock);
    i_Tx_DV = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge i_Clock);
  endtask

  task automatic wait_frames(input int n, input int budget);
    int k = 0;
    while (mon_frames < n && k < budget) begin
      @(negedge i_Clock);
      k++;
    end
    check("wait_frames", 32'(mon_frames >= n), 32'd1);
  endtask

  // Serial-line monitor: decodes each frame and checks its shape and byte.
  initial begin : monitor
    logic [7:0] data;
    bit         ok;
    bit         abort;
    forever begin
      @(negedge i_Clock);
      if (i_Reset_n === 1'b1 && o_Tx_Serial === 1'b0) begin
        start_q.push_back(cyc);
        mon_starts++;
        ok    = (o_Tx_Active === 1'b1);
        abort = 1'b0;
        data  = 8'h00;
        for (int i = 1; i < CPB; i++) begin
          @(negedge i_Clock);
          abort = abort || (i_Reset_n !== 1'b1);
          ok    = ok && (o_Tx_Serial === 1'b0) && (o_Tx_Active === 1'b1);
        end
        for (int b = 0; b < 8; b++) begin
          for (int c = 0; c < CPB; c++) begin
            @(negedge i_Clock);
            abort = abort || (i_Reset_n !== 1'b1);
            if (c == 0) data[b] = o_Tx_Serial;
            else ok = ok && (o_Tx_Serial === data[b]);
            ok = ok && (o_Tx_Active === 1'b1);
          end
        end
`ifdef UART_TX_PARITY_EN
        for (int c = 0; c < CPB; c++) begin
          @(negedge i_Clock);
          abort = abort || (i_Reset_n !== 1'b1);
          ok    = ok && (o_Tx_Serial === ^data) && (o_Tx_Active === 1'b1);
        end
`endif
        for (int c = 0; c < CPB; c++) begin
          @(negedge i_Clock);
          abort = abort || (i_Reset_n !== 1'b1);
          ok    = ok && (o_Tx_Serial === 1'b1) && (o_Tx_Active === 1'b1);
        end
        @(negedge i_Clock);
        abort = abort || (i_Reset_n !== 1'b1);
        if (!abort) begin
          check("frame_shape", 32'(ok), 32'd1);
          check("cleanup_done_active_serial", {29'd0, o_Tx_Done, o_Tx_Active, o_Tx_Serial}, 32'h5);
          check("frame_expected", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) check("rx_byte", 32'(data), 32'(exp_q.pop_front()));
          mon_frames++;
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int base;
    int k;
    int s;
    int viol;

    // Reset state
    i_Reset_n = 1'b0;
    #12;
    check("rst_serial",   32'(o_Tx_Serial), 32'd1);
    check("rst_active",   32'(o_Tx_Active), 32'd0);
    check("rst_done",     32'(o_Tx_Done),   32'd0);
    check("rst_overflow", 32'(o_Overflow),  32'd0);
    check("rst_empty",    32'(o_Empty),     32'd1);
    check("rst_full",     32'(o_Full),      32'd0);
    @(negedge i_Clock);
    i_Reset_n = 1'b1;
    wait_cycles(3);

    // Single byte 0x55: shape, one-cycle latency, one done pulse
    write_byte(8'h55, 1'b1);
    dv_off();
    wait_frames(1, 200);
    check("start_latency", 32'(start_q[0] - wr_cyc), 32'd1);
    wait_cycles(10);
    check("done_pulses", 32'(done_cnt), 32'd1);
    check("idle_empty", 32'(o_Empty), 32'd1);
    check("idle_serial", 32'(o_Tx_Serial), 32'd1);

    // Back-to-back 0xA3, 0x0F, 0xFF: order and start-to-start spacing
    start_q.delete();
    base = mon_frames;
    k    = mon_starts;
    write_byte(8'hA3, 1'b1);
    write_byte(8'h0F, 1'b1);
    write_byte(8'hFF, 1'b1);
    dv_off();
    s = 0;
    while (mon_starts < k + 3 && s < 400) begin
      @(negedge i_Clock);
      s++;
    end
    check("third_start_seen", 32'(mon_starts >= k + 3), 32'd1);
    check("empty_after_3rd_pop", 32'(o_Empty), 32'd1);
    wait_frames(base + 3, 200);
    if (start_q.size() >= 3) begin
      check("spacing_1_2", 32'(start_q[1] - start_q[0]), 32'(SPACING));
      check("spacing_2_3", 32'(start_q[2] - start_q[1]), 32'(SPACING));
    end else begin
      check("start_count", 32'(start_q.size()), 32'd3);
    end

    // Fill while a frame is in progress: full after 8, 9th dropped with overflow
    wait_cycles(5);
    base = mon_frames;
    write_byte(8'h81, 1'b1);
    dv_off();
    wait_cycles(2);
    for (int i = 0; i < 8; i++) write_byte(8'(8'h10 + i), 1'b1);
    @(negedge i_Clock);
    check("full_after_8", 32'(o_Full), 32'd1);
    check("no_overflow_yet", 32'(o_Overflow), 32'd0);
    i_Tx_Byte = 8'h99;
    @(negedge i_Clock);
    i_Tx_DV = 1'b0;
    check("overflow_pulse", 32'(o_Overflow), 32'd1);
    check("still_full", 32'(o_Full), 32'd1);
    @(negedge i_Clock);
    check("overflow_one_cycle", 32'(o_Overflow), 32'd0);
    wait_frames(base + 9, 9 * (SPACING + 10) + 100);
    wait_cycles(60);
    check("frames_after_fill", 32'(mon_frames - base), 32'd9);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    // Reset mid-DATA of 0x3C with two bytes queued
    base = mon_frames;
    k    = mon_starts;
    write_byte(8'h3C, 1'b1);
    write_byte(8'h11, 1'b1);
    write_byte(8'h22, 1'b1);
    dv_off();
    s = 0;
    while (mon_starts <= k && s < 100) begin
      @(negedge i_Clock);
      s++;
    end
    check("abort_frame_started", 32'(mon_starts > k), 32'd1);
    s = (start_q.size() > 0) ? start_q[$] : cyc;
    k = 0;
    while (cyc < s + 2 * CPB + 1 && k < 100) begin
      @(negedge i_Clock);
      k++;
    end
    check("serial_before_reset", 32'(o_Tx_Serial), 32'd0);
    check("active_before_reset", 32'(o_Tx_Active), 32'd1);
    #1;
    i_Reset_n = 1'b0;
    #1;
    check("async_rst_serial", 32'(o_Tx_Serial), 32'd1);
    check("async_rst_active", 32'(o_Tx_Active), 32'd0);
    check("async_rst_empty",  32'(o_Empty),     32'd1);
    check("async_rst_full",   32'(o_Full),      32'd0);
    exp_q.delete();
    wait_cycles(3);
    i_Reset_n = 1'b1;
    viol = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge i_Clock);
      if (o_Tx_Serial !== 1'b1 || o_Tx_Active !== 1'b0 || o_Tx_Done !== 1'b0) viol++;
    end
    check("quiet_after_release", 32'(viol), 32'd0);
    check("no_frames_after_release", 32'(mon_frames - base), 32'd0);
    check("empty_after_release", 32'(o_Empty), 32'd1);
    check("final_scoreboard", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
